// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and its wait counter.
//   APB_ADDR_W / APB_DATA_W : bus widths
//   CNT_W                   : wait-counter width (covers TIMEOUT_CYCLES up to 255)
//   apb_state_e             : master FSM state encoding
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;
endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to zero (held outside ACCESS)
//   enable   : count one more wait cycle
//   expired  : count equals TIMEOUT_CYCLES-1
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the terminal count; the master leaves ACCESS on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a valid/ready command port to APB.
//   PCLK, PRESET             : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : request handshake and payload
//   rsp_valid/ready/rdata/err/timeout : response handshake and status
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : APB requester outputs
//   PRDATA, PREADY, PSLVERR  : APB completer inputs
//
// state  | meaning
// IDLE   | ready for a command; bus idle
// SETUP  | first PSEL cycle, PENABLE low
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | response held on rsp_* until consumed
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  expired;

  // Counter rests at zero outside ACCESS so it always starts from 0 on entry.
  assign cnt_clear  = (state_q != ST_ACCESS);
  assign cnt_enable = (state_q == ST_ACCESS) && !PREADY;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY wins over expiry in the terminal-count cycle.
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_cyc;   // PREADY low for this many ACCESS cycles (255 = never ready)
    logic [31:0] prdata;
    logic        pslverr;
    int          hold;       // cycles rsp_ready stays low in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
    int          exp_access;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Protocol monitor: PENABLE never without PSEL.
  always @(negedge PCLK) begin
    if (PRESET === 1'b0 && PENABLE === 1'b1) chk("penable_implies_psel", {31'd0, PSEL}, 32'd1);
  end

  task automatic run_txn(input vec_t v);
    rsp_t exp_r, got_r;
    int   n;
    bit   done;
    @(negedge PCLK);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_psel", {31'd0, PSEL}, 32'd0);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PRDATA    = v.prdata;
    PSLVERR   = v.pslverr;
    PREADY    = 1'b0;
    exp_r.rdata = v.exp_rdata;
    exp_r.err   = v.exp_err;
    exp_r.tmo   = v.exp_tmo;
    sb_q.push_back(exp_r);
    @(negedge PCLK);   // SETUP
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0BAD_0BAD;
    cmd_write = ~v.write;
    chk("setup_psel", {31'd0, PSEL}, 32'd1);
    chk("setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("setup_paddr", PADDR, v.addr);
    n = 0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        n++;
        chk("access_paddr", PADDR, v.addr);
        chk("access_pwrite", {31'd0, PWRITE}, {31'd0, v.write});
        if (v.write) chk("access_pwdata", PWDATA, v.wdata);
        chk("access_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        PREADY = (n > v.wait_cyc);
      end else begin
        done = 1;
      end
    end
    PREADY = 1'b0;
    chk("access_cycles", n, v.exp_access);
    chk("rsp_valid_after_access", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      got_r.rdata = rsp_rdata;
      got_r.err   = rsp_err;
      got_r.tmo   = rsp_timeout;
      if (sb_q.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        exp_r = sb_q.pop_front();
        chk("rsp_rdata", got_r.rdata, exp_r.rdata);
        chk("rsp_err", {31'd0, got_r.err}, {31'd0, exp_r.err});
        chk("rsp_timeout", {31'd0, got_r.tmo}, {31'd0, exp_r.tmo});
      end
      for (int h = 0; h < v.hold; h++) begin
        @(negedge PCLK);
        chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("hold_rsp_flags", {30'd0, rsp_err, rsp_timeout}, {30'd0, v.exp_err, v.exp_tmo});
        chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("hold_psel", {30'd0, PSEL, PENABLE}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk("back_to_idle", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    end
  endtask

  vec_t vecs[8];

  initial begin
    // write | addr | wdata | wait | prdata | slverr | hold | exp_rdata | err | tmo | access
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF,   0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h20, 32'h0,          3, 32'h12345678, 1'b0, 0, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h30, 32'h0,          0, 32'h000000AA, 1'b1, 0, 32'h000000AA, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h40, 32'h0,        255, 32'h55555555, 1'b0, 0, 32'h0,        1'b1, 1'b1, 4};
    vecs[4] = '{1'b1, 32'h44, 32'hCAFEF00D,   2, 32'h77777777, 1'b1, 0, 32'h0,        1'b1, 1'b0, 3};
    vecs[5] = '{1'b0, 32'h48, 32'h0,          1, 32'hA5A5A5A5, 1'b0, 5, 32'hA5A5A5A5, 1'b0, 1'b0, 2};
    vecs[6] = '{1'b1, 32'h4C, 32'h01020304, 255, 32'h99999999, 1'b0, 0, 32'h0,        1'b1, 1'b1, 4};
    vecs[7] = '{1'b0, 32'h50, 32'h0,          2, 32'h0F0F0F0F, 1'b0, 0, 32'h0F0F0F0F, 1'b0, 1'b0, 3};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_ctrl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    for (int k = 0; k < 8; k++) run_txn(vecs[k]);

    // Reset in the second ACCESS cycle drops the transfer.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; PREADY = 1'b0;
    @(negedge PCLK);   // SETUP
    cmd_valid = 1'b0;
    @(negedge PCLK);   // ACCESS 1
    chk("rstseq_access1", {30'd0, PSEL, PENABLE}, 32'd3);
    @(negedge PCLK);   // ACCESS 2
    chk("rstseq_access2", {30'd0, PSEL, PENABLE}, 32'd3);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rstseq_bus_idle", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
    chk("rstseq_paddr", PADDR, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rstseq_cmd_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    repeat (3) begin
      @(negedge PCLK);
      chk("rstseq_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    run_txn(vecs[1]);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles waited for PREADY before abort; legal range 2..255.
REQ-002 PCLK  input  1  single clock; all logic on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  request present.
REQ-005 cmd_ready  output  1  master accepts request.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  transfer address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 rsp_err  output  1  PSLVERR sampled or timeout.
REQ-013 rsp_timeout  output  1  transfer aborted by timeout.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 PADDR, PWDATA  output  32 each  APB address and write data.
REQ-016 PRDATA  input  32; PREADY, PSLVERR  input  1 each.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-018 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; cmd_valid&cmd_ready latches cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and moves to SETUP next cycle.
REQ-019 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP; only one transfer is outstanding.
REQ-020 SETUP lasts exactly one cycle: PSEL=1, PENABLE=0, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PWDATA SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-022 ACCESS with PREADY=1 completes: PRDATA (reads only) and PSLVERR are captured into rsp_rdata/rsp_err, rsp_timeout=0, then RESP.
REQ-023 ACCESS wait counter starts at 0 on ACCESS entry and increments each PREADY=0 cycle; PREADY=0 while the counter equals TIMEOUT_CYCLES-1 aborts: rsp_err=1, rsp_timeout=1, rsp_rdata=0, then RESP.
REQ-024 PREADY=1 in the same cycle the counter reaches TIMEOUT_CYCLES-1 is a normal completion, not a timeout.
REQ-025 RESP: PSEL=0, PENABLE=0, rsp_valid=1 with rsp_* held stable until rsp_valid&rsp_ready, then IDLE.
REQ-026 Minimum latency, zero-wait slave: acceptance cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3; next acceptance no earlier than N+4.
REQ-027 PENABLE=1 SHALL never occur with PSEL=0; PENABLE SHALL never be 1 in the first PSEL cycle of a transfer.
REQ-028 A write response SHALL have rsp_rdata=0 regardless of PRDATA.

Reset
REQ-029 PRESET=1 sampled at a PCLK edge forces IDLE next cycle, from any state including mid-ACCESS, and drops the in-flight transfer with no response.
REQ-030 Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0; cmd_ready=1 in the first cycle after reset is released.

Structure
REQ-031 Shared package apb_pkg SHALL hold APB_ADDR_W=32, APB_DATA_W=32 and the FSM state enum type.
REQ-032 The wait counter SHALL be the sub-module apb_timeout_cnt (inputs clear and enable; output expired, asserted when the count equals TIMEOUT_CYCLES-1); all other logic stays in apb_master.

Verification
REQ-033 Write addr 0x10, data 0xDEADBEEF, PREADY=1 -> PSEL rises N+1, PENABLE N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-034 Read addr 0x20, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> 4 ACCESS cycles, PADDR stable, rsp_rdata=0x12345678.
REQ-035 Read with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-036 TIMEOUT_CYCLES=4, PREADY held 0 -> exactly 4 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-038 PRESET asserted in 2nd ACCESS cycle -> next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after release; the next command completes normally.
